receptor_logic: RTL

Receive-side counterpart of the transmit-side full logic. It drains the two destination FIFOs (D0, D1) with round-robin pops and merges their 6-bit words into one internal output FIFO. Upstream pops are throttled against a programmable threshold, and the block reports its state on active/idle/error outputs, the same way the transmit side does.

---
 rtl/receptor_logic.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/receptor_logic.sv
// receptor_logic: drains destination FIFOs D0/D1 round-robin into a 2^address_width-deep output FIFO.
// Build macro RX_DEST_CHECK_EN: when defined, a written word whose bit 5 disagrees with its channel raises ERROR.
module receptor_logic #(
  parameter int data_width    = 6,
  parameter int address_width = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [3:0]            umbral_Rx,
  input  logic [data_width-1:0] data_in_D0,
  input  logic [data_width-1:0] data_in_D1,
  input  logic                  empty_D0,
  input  logic                  empty_D1,
  output logic                  pop_D0,
  output logic                  pop_D1,
  input  logic                  pop_out,
  output logic [data_width-1:0] data_out,
  output logic                  empty_out,
  output logic                  almost_full_out,
  output logic                  active_out,
  output logic                  idle_out,
  output logic                  error_out
);

  localparam logic [3:0] depth_thr = 4'(2 ** address_width);

  typedef enum logic [2:0] {
    s_reset,
    s_init,
    s_idle,
    s_active,
    s_error
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [data_width-1:0]    mem [2 ** address_width];
  logic [address_width-1:0] wptr;
  logic [address_width-1:0] rptr;
  logic [address_width:0]   count;
  logic [address_width:0]   count_next;
  logic [3:0]               umbral_q;
  logic [3:0]               umbral_next;
  logic                     inflight;
  logic                     tag;
  logic                     last_grant;
  logic                     serve;
  logic                     grant;
  logic                     do_write;
  logic                     do_read;
  logic                     underflow;
  logic                     dest_err;
  logic                     thr_legal;
  logic [data_width-1:0]    wdata;

  always_comb begin
    serve = 1'b0;
    if ((state == s_idle) || (state == s_active)) begin
      serve = ((4'(count) + 4'(inflight)) < umbral_q) && !(empty_D0 && empty_D1);
    end

    // both pending: take the channel not served last; otherwise whichever has data
    if (!empty_D0 && !empty_D1) begin
      grant = ~last_grant;
    end else begin
      grant = empty_D0;
    end

    pop_D0 = serve && !grant;
    pop_D1 = serve && grant;

    wdata     = tag ? data_in_D1 : data_in_D0;
    do_write  = inflight && ((state == s_init) || (state == s_idle) || (state == s_active));
    do_read   = pop_out && !empty_out && (state != s_reset);
    underflow = pop_out && empty_out &&
                ((state == s_init) || (state == s_idle) || (state == s_active));
`ifdef RX_DEST_CHECK_EN
    dest_err  = do_write && (wdata[data_width-1] != tag);
`else
    dest_err  = 1'b0;
`endif
    thr_legal = (umbral_q != 4'd0) && (umbral_q <= depth_thr);

    case ({do_write, do_read})
      2'b10:   count_next = count + (address_width + 1)'(1);
      2'b01:   count_next = count - (address_width + 1)'(1);
      default: count_next = count;
    endcase

    umbral_next = ((state == s_init) && init) ? umbral_Rx : umbral_q;

    state_next = state;
    case (state)
      s_reset: state_next = s_init;
      s_init: begin
        if (underflow || dest_err) begin
          state_next = s_error;
        end else if (!init) begin
          state_next = thr_legal ? s_idle : s_error;
        end
      end
      s_idle: begin
        if (underflow || dest_err) begin
          state_next = s_error;
        end else if (init) begin
          state_next = s_init;
        end else if (!empty_D0 || !empty_D1 || (count != '0)) begin
          state_next = s_active;
        end
      end
      s_active: begin
        if (underflow || dest_err) begin
          state_next = s_error;
        end else if (init) begin
          state_next = s_init;
        end else if (empty_D0 && empty_D1 && (count == '0) && !inflight) begin
          state_next = s_idle;
        end
      end
      s_error: state_next = s_error;
      default: state_next = s_reset;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset && do_write) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= s_reset;
      wptr            <= '0;
      rptr            <= '0;
      count           <= '0;
      umbral_q        <= '0;
      inflight        <= 1'b0;
      tag             <= 1'b0;
      last_grant      <= 1'b1;
      data_out        <= '0;
      empty_out       <= 1'b1;
      almost_full_out <= 1'b0;
      active_out      <= 1'b0;
      idle_out        <= 1'b0;
      error_out       <= 1'b0;
    end else begin
      state    <= state_next;
      umbral_q <= umbral_next;
      count    <= count_next;
      inflight <= pop_D0 | pop_D1;
      if (serve) begin
        tag        <= grant;
        last_grant <= grant;
      end
      if (do_write) begin
        wptr <= wptr + (address_width)'(1);
      end
      if (do_read) begin
        rptr     <= rptr + (address_width)'(1);
        data_out <= mem[rptr];
      end
      empty_out       <= (count_next == '0);
      almost_full_out <= (umbral_next != 4'd0) && (4'(count_next) >= umbral_next);
      active_out      <= (state_next == s_active);
      idle_out        <= (state_next == s_idle);
      error_out       <= (state_next == s_error);
    end
  end

endmodule
